regfile_wr_arbiter: RTL and testbench

- Owns the single write port (WE3/AD3/WD3) of the 32-entry register file.
- After reset, a clear sequence writes zero to every register except x0, because the register file has no reset of its own.
- It then shares the write port between two writeback requesters (req0 = ALU result, req1 = load/memory result) using round-robin valid/ready arbitration.
- It sits between the writeback stage and the register file in the top level.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/rr_arbiter2.sv | 18 +
 rtl/regfile_wr_arbiter.sv | 105 ++++++++++
 tb/tb_regfile_wr_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-port logic.
package regfile_pkg;

    localparam int REG_BITS_DEFAULT = 5;
    localparam int REG_COUNT        = 2 ** REG_BITS_DEFAULT;
    localparam int ZERO_REG         = 0;

    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } wr_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the
// requester that was not granted last. Grant is one-hot or zero.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = (last_grant == 1'(REQ_MEM)) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Owns the register-file write port: zero-fills x1..xN after reset, then
// shares the port between the ALU and memory writeback requesters.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int REGISTER_BIT = REG_BITS_DEFAULT,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0_valid,
    input  logic [REGISTER_BIT-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0]   req0_data,
    output logic                    req0_ready,
    input  logic                    req1_valid,
    input  logic [REGISTER_BIT-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0]   req1_data,
    output logic                    req1_ready,
    output logic                    we3,
    output logic [REGISTER_BIT-1:0] ad3,
    output logic [DATA_WIDTH-1:0]   wd3,
    output logic                    init_done
);

    localparam int CNT_W = REGISTER_BIT + 1;
    // The counter runs one past the last address; that value ends the clear.
    localparam logic [CNT_W-1:0] CLR_END = CNT_W'(2 ** REGISTER_BIT);

    wr_state_t                state, state_next;
    logic [CNT_W-1:0]         clr_cnt;
    logic                     last_grant;
    logic [1:0]               grant;
    logic                     accept;
    logic                     sel;
    logic [REGISTER_BIT-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]    sel_data;

    rr_arbiter2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; combinational blocks use blocking (=) with defaults first.
    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == CLEAR && clr_cnt == CLR_END) state_next = RUN;
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state == RUN) begin
            req0_ready = grant[REQ_ALU];
            req1_ready = grant[REQ_MEM];
        end
    end

    assign accept   = req0_ready | req1_ready;
    assign sel      = req1_ready;
    assign sel_addr = sel ? req1_addr : req0_addr;
    assign sel_data = sel ? req1_data : req0_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt    <= CNT_W'(1);
            last_grant <= 1'(REQ_MEM);
            we3        <= 1'b0;
            ad3        <= '0;
            wd3        <= '0;
            init_done  <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_cnt == CLR_END) begin
                        we3       <= 1'b0;
                        init_done <= 1'b1;
                    end else begin
                        we3     <= 1'b1;
                        ad3     <= clr_cnt[REGISTER_BIT-1:0];
                        wd3     <= '0;
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                RUN: begin
                    // x0 writes are granted so the requester drains, but never reach the port.
                    we3 <= accept && (sel_addr != REGISTER_BIT'(ZERO_REG));
                    if (accept) begin
                        ad3        <= sel_addr;
                        wd3        <= sel_data;
                        last_grant <= sel;
                    end
                end
                default: we3 <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench: directed steps plus constrained-random traffic against
// a grant-order model and a shadow register file fed from the write port.
module tb_regfile_wr_arbiter;

    localparam int NREG = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        we3;
    logic [4:0]  ad3;
    logic [31:0] wd3;
    logic        init_done;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.REGISTER_BIT(5), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .we3        (we3),
        .ad3        (ad3),
        .wd3        (wd3),
        .init_done  (init_done)
    );

    int passed = 0;
    int total  = 0;

    // Reference model state: who was granted last, expected port, expected regfile.
    logic        m_last;
    logic        m_we;
    logic [4:0]  m_ad;
    logic [31:0] m_wd;
    logic [31:0] exp_rf [NREG];
    logic [31:0] dut_rf [NREG];

    // Shadow register file: every write on the port lands here.
    always @(negedge clk) if (we3) dut_rf[ad3] <= wd3;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clear_seq();
        req0_valid = 1'b1; req0_addr = 5'd9;  req0_data = 32'h1234_5678;
        req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 32'h8765_4321;
        for (int k = 1; k < NREG; k++) begin
            @(negedge clk);
            check($sformatf("clear_%0d", k),
                  64'({we3, ad3, wd3, init_done, req0_ready, req1_ready}),
                  64'({1'b1, 5'(k), 32'h0, 3'b000}));
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check("clear_done", 64'({we3, init_done, req0_ready, req1_ready}), 64'(4'b0100));
        m_last = 1'b1;
        m_we   = 1'b0;
        m_ad   = 5'd31;
        m_wd   = 32'h0;
        for (int i = 1; i < NREG; i++) exp_rf[i] = 32'h0;
    endtask

    // One RUN cycle: drive at negedge, check grant, then check the port after the posedge.
    task automatic drive_cycle(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                               input string tag, output int gnt);
        logic [4:0]  addr;
        logic [31:0] data;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        #1;
        if (v0 && v1)  gnt = m_last ? 0 : 1;
        else if (v0)   gnt = 0;
        else if (v1)   gnt = 1;
        else           gnt = -1;
        check({tag, "_ready"}, 64'({req0_ready, req1_ready}), 64'({gnt == 0, gnt == 1}));
        if (gnt >= 0) begin
            addr   = (gnt == 1) ? a1 : a0;
            data   = (gnt == 1) ? d1 : d0;
            m_last = (gnt == 1);
            m_we   = (addr != 5'd0);
            m_ad   = addr;
            m_wd   = data;
            if (addr != 5'd0) exp_rf[addr] = data;
        end else begin
            m_we = 1'b0;
        end
        @(negedge clk);
        check({tag, "_port"}, 64'({we3, ad3, wd3}), 64'({m_we, m_ad, m_wd}));
    endtask

    initial begin
        int          g;
        logic        p0v, p1v;
        logic [4:0]  p0a, p1a;
        logic [31:0] p0d, p1d;

        for (int i = 0; i < NREG; i++) begin
            dut_rf[i] = 32'hA5A5_0000 | 32'(i);
            exp_rf[i] = 32'hA5A5_0000 | 32'(i);
        end
        rst = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        repeat (2) @(negedge clk);
        check("reset_state", 64'({we3, ad3, wd3, init_done, req0_ready, req1_ready}), 64'(0));
        rst = 1'b0;
        clear_seq();

        drive_cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, "t1", g);
        check("t1_grant", 64'(g), 64'(0));
        check("t1_write", 64'({we3, ad3, wd3}), 64'({1'b1, 5'd5, 32'hDEAD_BEEF}));
        drive_cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, "t1_idle", g);
        check("t1_we_low", 64'(we3), 64'(0));

        drive_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFF, "x0", g);
        check("x0_grant", 64'(g), 64'(1));
        check("x0_dropped", 64'(we3), 64'(0));

        for (int j = 0; j < 4; j++) begin
            drive_cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, "alt", g);
            check($sformatf("alt_grant_%0d", j), 64'(g), 64'(j % 2));
            check($sformatf("alt_addr_%0d", j), 64'({we3, ad3}),
                  64'({1'b1, (j % 2 == 1) ? 5'd4 : 5'd3}));
        end

        p0v = 1'b0; p1v = 1'b0;
        p0a = '0; p1a = '0; p0d = '0; p1d = '0;
        g = -1;
        for (int i = 0; i < 400; i++) begin
            // A requester not yet granted keeps its request unchanged.
            if (!(p0v && g != 0)) begin
                p0v = ($urandom % 3) != 0; p0a = 5'($urandom); p0d = $urandom;
            end
            if (!(p1v && g != 1)) begin
                p1v = ($urandom % 3) != 0; p1a = 5'($urandom); p1d = $urandom;
            end
            drive_cycle(p0v, p0a, p0d, p1v, p1a, p1d, "rnd", g);
        end
        drive_cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, "drain", g);
        #1;
        for (int i = 1; i < NREG; i++)
            check($sformatf("rf_x%0d", i), 64'(dut_rf[i]), 64'(exp_rf[i]));
        check("rf_x0_untouched", 64'(dut_rf[0]), 64'(32'hA5A5_0000));

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("pre_abort_%0d", k), 64'({we3, ad3, init_done}), 64'({1'b1, 5'(k), 1'b0}));
        end
        rst = 1'b1;
        @(negedge clk);
        check("abort_reset", 64'({we3, ad3, wd3, init_done}), 64'(0));
        rst = 1'b0;
        clear_seq();

        rst = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77;
        @(negedge clk);
        check("run_reset", 64'({we3, init_done, ad3, wd3}), 64'(0));
        rst = 1'b0;
        req0_valid = 1'b0;
        clear_seq();

        drive_cycle(1'b1, 5'd9, 32'hAAAA, 1'b1, 5'd10, 32'hBBBB, "tie_after_reset", g);
        check("tie_after_reset_grant", 64'(g), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
